button_conditioner: RTL

//   Upstream front end of the countdown timer. Takes the two raw, asynchronous,

---
 rtl/button_pkg.sv | 35 +++
 rtl/button_channel.sv | 151 +++++++++++++++
 rtl/button_conditioner.sv | 115 +++++++++++
 3 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button front end of the countdown timer:
// per-channel debounce state encoding, default timing constants and a small
// helper that tells whether a state counts as "button held".
package button_pkg;

    // Debounce FSM states; the encoding is fixed so the state can be probed
    // directly on a bus or in a waveform.
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_e;

    // Consecutive equal synchronised samples needed to accept a level change.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 32'd4;

    // Cycles ENTER must remain accepted-pressed before the long-press strobe.
    localparam int unsigned LONG_CYCLES_DEF = 32'd32;

    // A button is considered down while pressed or while a release is still
    // being qualified (release bounce must not drop the level).
    function automatic logic is_down(input btn_state_e st);
        logic down;
        case (st)
            PRESSED:      down = 1'b1;
            RELEASE_WAIT: down = 1'b1;
            IDLE:         down = 1'b0;
            PRESS_WAIT:   down = 1'b0;
            default:      down = 1'b0;
        endcase
        return down;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One push-button channel: two-flop synchroniser, debounce FSM with its
// sample counter, and (when LONG_EN is set) a saturating hold counter that
// produces a single long-press strobe per press.
// The strobe/level outputs are combinational from this block's flops and
// are registered by the parent so all module outputs stay registered while
// meeting the press-to-strobe latency.
module button_channel
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF,
    parameter bit          LONG_EN         = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic strobe_o,
    output logic long_o,
    output logic lvl_o
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES + 1);

    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

    logic [1:0]        sync_q;
    logic [1:0]        sync_d;
    btn_state_e        state_q;
    btn_state_e        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [HOLD_W-1:0] hold_q;
    logic [HOLD_W-1:0] hold_d;
    logic              s_s;
    logic              strobe_s;
    logic              long_s;

    assign s_s = sync_q[1];

    // Shift the raw asynchronous level through the two synchroniser stages.
    always_comb begin
        sync_d = {sync_q[0], btn_raw};
    end

    // Debounce FSM: qualify a press or release by DEBOUNCE_CYCLES equal samples.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        strobe_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    strobe_s = 1'b1;
                end else begin
                    state_d = PRESS_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end else begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                // Going back to PRESSED here is release bounce: no new strobe.
                if (s_s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Hold counter: restarts only on a fresh press, saturates, and fires once
    // as it crosses LONG_CYCLES so a held or bouncing button never re-fires.
    always_comb begin
        hold_d = hold_q;
        long_s = 1'b0;
        if (LONG_EN == 1'b0) begin
            hold_d = '0;
        end else if ((state_q == PRESS_WAIT) && (state_d == PRESSED)) begin
            hold_d = '0;
        end else if (is_down(state_q)) begin
            if (hold_q != HOLD_MAX) begin
                hold_d = hold_q + HOLD_ONE;
            end else begin
                hold_d = hold_q;
            end
            if (hold_q == HOLD_LAST) begin
                long_s = 1'b1;
            end else begin
                long_s = 1'b0;
            end
        end else begin
            hold_d = hold_q;
        end
    end

    // Channel state registers with synchronous reset back to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= 2'b00;
            state_q <= IDLE;
            cnt_q   <= '0;
            hold_q  <= '0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hold_q  <= hold_d;
        end
    end

    assign strobe_o = strobe_s;
    assign long_o   = long_s;
    assign lvl_o    = is_down(state_d);

endmodule

// File: rtl/button_conditioner.sv
// Front end of the countdown timer: conditions the raw ENTER and PAUSE
// buttons into clean one-cycle command strobes plus debounced levels and an
// ENTER long-press strobe. This level only arbitrates ENTER against PAUSE
// (a colliding PAUSE is deferred by one cycle, never lost) and registers
// every output.
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_ENTER_RAW,
    input  logic BTN_PAUSE_RAW,
    output logic ENTER,
    output logic PAUSE,
    output logic ENTER_LONG,
    output logic ENTER_LVL,
    output logic PAUSE_LVL
);

    logic enter_strb_s;
    logic enter_long_s;
    logic enter_lvl_s;
    logic pause_strb_s;
    logic pause_long_s;
    logic pause_lvl_s;

    logic enter_q;
    logic enter_d;
    logic pause_q;
    logic pause_d;
    logic long_q;
    logic long_d;
    logic enter_lvl_q;
    logic enter_lvl_d;
    logic pause_lvl_q;
    logic pause_lvl_d;
    logic pend_q;
    logic pend_d;

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .LONG_EN         (1'b1)
    ) u_enter_ch (
        .clk      (CLK),
        .rst      (RST),
        .btn_raw  (BTN_ENTER_RAW),
        .strobe_o (enter_strb_s),
        .long_o   (enter_long_s),
        .lvl_o    (enter_lvl_s)
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .LONG_CYCLES     (LONG_CYCLES),
        .LONG_EN         (1'b0)
    ) u_pause_ch (
        .clk      (CLK),
        .rst      (RST),
        .btn_raw  (BTN_PAUSE_RAW),
        .strobe_o (pause_strb_s),
        .long_o   (pause_long_s),
        .lvl_o    (pause_lvl_s)
    );

    // Arbitrate strobes: ENTER wins a collision, PAUSE waits in a 1-deep slot.
    always_comb begin
        enter_d     = enter_strb_s;
        // Only the ENTER channel has its hold counter enabled; PAUSE's is tied low.
        long_d      = enter_long_s | pause_long_s;
        enter_lvl_d = enter_lvl_s;
        pause_lvl_d = pause_lvl_s;
        pause_d     = 1'b0;
        pend_d      = pend_q;
        if (enter_strb_s) begin
            pause_d = 1'b0;
            pend_d  = pend_q | pause_strb_s;
        end else if (pend_q) begin
            pause_d = 1'b1;
            pend_d  = pause_strb_s;
        end else begin
            pause_d = pause_strb_s;
            pend_d  = 1'b0;
        end
    end

    // Output and pending-flag registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            enter_q     <= 1'b0;
            pause_q     <= 1'b0;
            long_q      <= 1'b0;
            enter_lvl_q <= 1'b0;
            pause_lvl_q <= 1'b0;
            pend_q      <= 1'b0;
        end else begin
            enter_q     <= enter_d;
            pause_q     <= pause_d;
            long_q      <= long_d;
            enter_lvl_q <= enter_lvl_d;
            pause_lvl_q <= pause_lvl_d;
            pend_q      <= pend_d;
        end
    end

    assign ENTER      = enter_q;
    assign PAUSE      = pause_q;
    assign ENTER_LONG = long_q;
    assign ENTER_LVL  = enter_lvl_q;
    assign PAUSE_LVL  = pause_lvl_q;

endmodule
